// File: rtl/dbg_reg_access.sv
// rtl/dbg_reg_access.sv - debugger-side GPR access initiator: halt handshake, single-cycle register file access, one response per command
module dbg_reg_access #(
    parameter int unsigned HALT_TIMEOUT = 1024,
    parameter logic [15:0] GPR_BASE     = 16'h1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_regno,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_err,
    input  logic        core_halted,
    output logic        halt_req,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] rf_wdata,
    output logic        rf_we
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HALT_WAIT = 2'd1;
    localparam logic [1:0] ST_ACCESS    = 2'd2;
    localparam logic [1:0] ST_RESP      = 2'd3;

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_REGNO = 3'd2;
    localparam logic [2:0] ERR_HALT  = 3'd4;

    localparam int unsigned     CNT_W    = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [4:0]       idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             halt_req_q, halt_req_d;
    logic [4:0]       rf_addr_q, rf_addr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             rf_we_q, rf_we_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_err_q, rsp_err_d;

    logic        cmd_hs;
    logic        rsp_hs;
    logic [16:0] regno_off;
    logic        regno_ok;
    logic        acc_go;
    logic        acc_write;
    logic [4:0]  acc_idx;
    logic [31:0] acc_wdata;

    // Borrow out of bit 16 flags regno < GPR_BASE; any bit above 4 flags regno past x31.
    assign regno_off = {1'b0, cmd_regno} - {1'b0, GPR_BASE};
    assign regno_ok  = (regno_off[16:5] == 12'd0);

    assign cmd_ready = rst_n & (state_q == ST_IDLE);
    assign cmd_hs    = cmd_valid & cmd_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_hs    = rsp_valid & rsp_ready;

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign halt_req = halt_req_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_we    = rf_we_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        halt_req_d = halt_req_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        rf_we_d    = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        acc_go     = 1'b0;
        acc_write  = write_q;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    write_d   = cmd_write;
                    idx_d     = regno_off[4:0];
                    wdata_d   = cmd_wdata;
                    acc_write = cmd_write;
                    acc_idx   = regno_off[4:0];
                    acc_wdata = cmd_wdata;
                    if (!regno_ok) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = ERR_REGNO;
                        rsp_data_d = 32'd0;
                    end else if (core_halted) begin
                        acc_go = 1'b1;
                    end else begin
                        halt_req_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_HALT_WAIT;
                    end
                end
            end
            ST_HALT_WAIT: begin
                if (core_halted) begin
                    acc_go = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RESP;
                    rsp_err_d  = ERR_HALT;
                    rsp_data_d = 32'd0;
                    halt_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d    = ST_RESP;
                rsp_err_d  = ERR_OK;
                rsp_data_d = (!write_q && rf_addr_q != 5'd0) ? rf_rdata : 32'd0;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d    = ST_IDLE;
                    halt_req_d = 1'b0;
                    rsp_data_d = 32'd0;
                    rsp_err_d  = ERR_OK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // x0 is hardwired: the access still completes, but the write strobe is suppressed.
        if (acc_go) begin
            state_d    = ST_ACCESS;
            rf_addr_d  = acc_idx;
            rf_wdata_d = acc_wdata;
            rf_we_d    = acc_write & (acc_idx != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            idx_q      <= 5'd0;
            wdata_q    <= 32'd0;
            halt_req_q <= 1'b0;
            rf_addr_q  <= 5'd0;
            rf_wdata_q <= 32'd0;
            rf_we_q    <= 1'b0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= ERR_OK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            halt_req_q <= halt_req_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_we_q    <= rf_we_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dbg_reg_access.sv
// tb/tb_dbg_reg_access.sv - randomized bench for dbg_reg_access against a command-level reference model
module tb_dbg_reg_access;

    localparam int          TO   = 16;
    localparam logic [15:0] BASE = 16'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_regno = 16'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_err;
    logic        core_halted = 1'b0;
    logic        halt_req;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic [31:0] rf_wdata;
    logic        rf_we;

    logic [31:0] rf_mem  [32];
    logic [31:0] exp_gpr [32];

    int n_vec = 0;
    int n_err = 0;

    dbg_reg_access #(.HALT_TIMEOUT(TO), .GPR_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_regno(cmd_regno), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_halted(core_halted), .halt_req(halt_req),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0000_0009;
        return 32'(32'h9E37_79B9 * (i + 1));
    endfunction

    // Register file model; x0 holds junk on purpose so a DUT that forwards it is caught.
    assign rf_rdata = rf_mem[rf_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_word(i);
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reinit_model();
        for (int i = 0; i < 32; i++) exp_gpr[i] = init_word(i);
    endtask

    // hdly: 0 = core already halted; 1..TO = core_halted rises in that cycle after acceptance; >TO = never.
    task automatic do_cmd(input bit wr, input logic [15:0] regno, input logic [31:0] wd,
                          input int hdly, input int rdly);
        int          idx;
        bit          in_rng, exp_hreq, exp_to, exp_we, drop_in_access;
        int          exp_lat, cyc, we_cnt, bad_ready, bad_halt, bad_hold;
        logic [2:0]  exp_err;
        logic [31:0] exp_data;
        logic [4:0]  we_addr;
        logic [31:0] we_data;
        logic [31:0] d0;
        logic [2:0]  e0;

        in_rng   = (int'(regno) >= int'(BASE)) && (int'(regno) <= int'(BASE) + 31);
        idx      = int'(regno) - int'(BASE);
        exp_hreq = in_rng && (hdly != 0);
        exp_to   = exp_hreq && (hdly > TO);
        if (!in_rng)        begin exp_err = 3'd2; exp_lat = 1;        end
        else if (hdly == 0) begin exp_err = 3'd0; exp_lat = 2;        end
        else if (exp_to)    begin exp_err = 3'd4; exp_lat = TO + 1;   end
        else                begin exp_err = 3'd0; exp_lat = hdly + 2; end
        exp_we   = in_rng && !exp_to && wr && (idx != 0);
        exp_data = 32'd0;
        if (in_rng && !exp_to && !wr && idx != 0) exp_data = exp_gpr[idx];
        drop_in_access = ($urandom_range(0, 1) == 1);

        chk("cmd_ready_idle", cmd_ready, 1);
        core_halted = (hdly == 0);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_regno   = regno;
        cmd_wdata   = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_regno = 16'($urandom);
        cmd_wdata = $urandom;

        cyc = 1; we_cnt = 0; bad_ready = 0; bad_halt = 0;
        we_addr = 5'd0; we_data = 32'd0;
        while (!rsp_valid && cyc < 64) begin
            if (rf_we) begin
                we_cnt++;
                we_addr = rf_addr;
                we_data = rf_wdata;
            end
            if (cmd_ready) bad_ready++;
            if (halt_req !== exp_hreq) bad_halt++;
            if (exp_hreq && !exp_to && cyc == hdly) core_halted = 1'b1;
            // core resuming during the access cycle must not disturb the committed access
            if (in_rng && !exp_to && cyc == exp_lat - 1 && drop_in_access) core_halted = 1'b0;
            tick();
            cyc++;
        end

        chk("rsp_arrives", rsp_valid, 1);
        chk("latency", cyc, exp_lat);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_data", rsp_data, exp_data);
        chk("rf_we_count", we_cnt, exp_we);
        if (exp_we) begin
            chk("rf_we_addr", we_addr, idx[4:0]);
            chk("rf_we_data", we_data, wd);
        end
        chk("cmd_ready_busy", bad_ready, 0);
        chk("halt_req_wait", bad_halt, 0);
        chk("halt_req_resp", halt_req, exp_hreq && !exp_to);
        chk("rf_we_resp", rf_we, 0);

        d0 = rsp_data; e0 = rsp_err; bad_hold = 0;
        repeat (rdly) begin
            tick();
            if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || cmd_ready || rf_we ||
                halt_req !== (exp_hreq && !exp_to)) bad_hold++;
        end
        chk("rsp_hold", bad_hold, 0);

        rsp_ready = 1'b1;
        tick();
        rsp_ready   = 1'b0;
        core_halted = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("halt_req_drop", halt_req, 0);
        chk("cmd_ready_back", cmd_ready, 1);

        if (exp_we) exp_gpr[idx] = wd;
    endtask

    initial begin
        int          bad;
        logic [15:0] rn;
        int          hd;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_halt_req", halt_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        rst_n = 1'b1;
        reinit_model();
        tick();
        chk("cmd_ready_after_rst", cmd_ready, 1);

        do_cmd(1'b1, 16'h1005, 32'hDEAD_BEEF, 0, 0);
        do_cmd(1'b0, 16'h1004, 32'h0, 0, 1);
        do_cmd(1'b0, 16'h1005, 32'h0, 0, 0);
        do_cmd(1'b0, 16'h100D, 32'h0, 5, 0);
        do_cmd(1'b1, 16'h1007, 32'h1234_5678, 99, 2);
        do_cmd(1'b0, 16'h2000, 32'h0, 0, 0);
        do_cmd(1'b1, 16'h0FFF, 32'hFFFF_FFFF, 3, 0);
        do_cmd(1'b1, 16'h1000, 32'hCAFE_F00D, 0, 10);
        do_cmd(1'b0, 16'h1000, 32'h0, 2, 0);
        do_cmd(1'b1, 16'h101F, 32'hA5A5_5A5A, TO, 1);
        do_cmd(1'b0, 16'h101F, 32'h0, 1, 0);
        do_cmd(1'b1, 16'h1020, 32'h1111_1111, 0, 0);

        // reset while waiting for the halt acknowledge drops the command
        core_halted = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_regno = 16'h1003; cmd_wdata = 32'h7777_7777;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("halt_req_pre_rst", halt_req, 1);
        chk("cmd_ready_pre_rst", cmd_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("halt_req_in_rst", halt_req, 0);
        chk("rsp_valid_in_rst", rsp_valid, 0);
        chk("cmd_ready_in_rst", cmd_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        reinit_model();
        core_halted = 1'b1;
        bad = 0;
        repeat (5) begin
            tick();
            if (rsp_valid || halt_req || rf_we || !cmd_ready) bad++;
        end
        chk("post_rst_idle", bad, 0);
        core_halted = 1'b0;

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 8) rn = BASE + 16'($urandom_range(0, 31));
            else                          rn = 16'($urandom);
            if ($urandom_range(0, 9) < 4) hd = 0;
            else                          hd = $urandom_range(1, TO + 4);
            do_cmd(1'($urandom), rn, $urandom, hd, $urandom_range(0, 3));
        end

        for (int i = 0; i < 32; i++) chk($sformatf("rf_mem[%0d]", i), rf_mem[i], exp_gpr[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
